user_id_readout: RTL and testbench

- Downstream consumer of the mask-programmed 32-bit user project ID word.
- On request, snapshots the ID into a shadow register and serializes it MSB-first on a bit-strobed serial output for the housekeeping/debug path.
- Also presents the captured word in parallel with a sticky valid flag.

---
 rtl/user_id_readout.sv | 113 +++++++++++
 tb/tb_user_id_readout.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/user_id_readout.sv
// rtl/user_id_readout.sv - snapshots the user project ID and serializes it MSB-first with a parallel sticky copy
// Optional feature macro: USER_ID_PARITY_EN appends one even-parity bit period after the data bits.

module user_id_readout #(
  parameter int ID_WIDTH = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ID_WIDTH-1:0] mask_rev,
  input  logic                start,
  input  logic                hold,
  input  logic                abort,
  output logic                busy,
  output logic                sdo,
  output logic                sdo_strobe,
  output logic                done,
  output logic [ID_WIDTH-1:0] id_word,
  output logic                id_valid
);

`ifdef USER_ID_PARITY_EN
  localparam int TOTAL = ID_WIDTH + 1;
`else
  localparam int TOTAL = ID_WIDTH;
`endif
  localparam int CNT_W = (TOTAL > 2) ? $clog2(TOTAL) : 1;
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic [TOTAL-1:0]    shadow;
  logic [ID_WIDTH-1:0] captured;
  logic [CNT_W-1:0]    bit_cnt;
  logic [7:0]          div_cnt;
  logic [TOTAL-1:0]    load_word;
  logic                wrap;

  // The parity bit rides in the shadow LSB so it naturally shifts out last.
`ifdef USER_ID_PARITY_EN
  assign load_word = {mask_rev, ^mask_rev};
`else
  assign load_word = mask_rev;
`endif

  assign wrap       = (div_cnt == DIV_LAST);
  assign sdo        = (state == SHIFT) && shadow[TOTAL-1];
  assign sdo_strobe = (state == SHIFT) && wrap && !hold;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      shadow   <= '0;
      captured <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      id_word  <= '0;
      id_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow   <= load_word;
            captured <= mask_rev;
            bit_cnt  <= BIT_LAST;
            div_cnt  <= '0;
            id_valid <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!hold) begin
            if (wrap) begin
              div_cnt <= '0;
              shadow  <= shadow << 1;
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == '0) begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          id_word  <= captured;
          id_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_id_readout.sv
// tb/tb_user_id_readout.sv - randomized self-checking bench for user_id_readout against a bit-sequence model
// Honors USER_ID_PARITY_EN when the design is built with it.

module tb_user_id_readout;

  localparam int ID_W    = 32;
  localparam int CLK_DIV = 4;
`ifdef USER_ID_PARITY_EN
  localparam int TOTAL = ID_W + 1;
`else
  localparam int TOTAL = ID_W;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [ID_W-1:0] mask_rev;
  logic            start, hold, abort;
  logic            busy, sdo, sdo_strobe, done, id_valid;
  logic [ID_W-1:0] id_word;

  int n_vec = 0;
  int n_err = 0;
  logic [ID_W-1:0] last_word = '0;

  user_id_readout #(.ID_WIDTH(ID_W), .CLK_DIV(CLK_DIV)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .mask_rev  (mask_rev),
    .start     (start),
    .hold      (hold),
    .abort     (abort),
    .busy      (busy),
    .sdo       (sdo),
    .sdo_strobe(sdo_strobe),
    .done      (done),
    .id_word   (id_word),
    .id_valid  (id_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: full readout, 1: abort at stop_at, 2: reset at stop_at
  task automatic readout(input logic [ID_W-1:0] word, input int hold_pct, input int mode, input int stop_at);
    bit seq[$];
    int ones;
    int active;
    int cycle;
    int limit;
    bit got_done;
    bit h;
    ones = 0;
    active = 0;
    got_done = 0;
    limit = TOTAL * CLK_DIV * 3 + 20;
    for (int i = ID_W - 1; i >= 0; i--) begin
      seq.push_back(word[i]);
      ones += int'(word[i]);
    end
`ifdef USER_ID_PARITY_EN
    seq.push_back(ones % 2 == 1);
`endif
    @(negedge clk);
    rst = 1'b0; mask_rev = word; start = 1'b1; hold = 1'b0; abort = 1'b0;
    #1 check_val("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    cycle = 1;
    while (cycle <= limit) begin
      h = ($urandom_range(99) < hold_pct);
      hold  = h;
      start = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) mask_rev = $urandom;
      abort = (mode == 1 && cycle == stop_at);
      rst   = (mode == 2 && cycle == stop_at);
      #1;
      if (active == TOTAL * CLK_DIV) begin
        check_val("done_pulse", done, 1);
        check_val("busy_in_done", busy, 1);
        got_done = 1;
        break;
      end
      check_val("done_early", done, 0);
      check_val("busy_shift", busy, 1);
      check_val("sdo_bit", sdo, seq[active / CLK_DIV]);
      if (!abort && !rst)
        check_val("strobe", sdo_strobe, (!h && (active % CLK_DIV == CLK_DIV - 1)));
      if (mode != 0 && cycle == stop_at) break;
      if (!h) active++;
      @(negedge clk);
      cycle++;
    end
    @(negedge clk);
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    #1;
    if (mode == 0) begin
      check_val("done_seen", got_done, 1);
      check_val("post_busy", busy, 0);
      check_val("post_done", done, 0);
      check_val("post_sdo", sdo, 0);
      check_val("id_word", id_word, word);
      check_val("id_valid", id_valid, 1);
      last_word = word;
    end else if (mode == 1) begin
      check_val("abort_busy", busy, 0);
      check_val("abort_sdo", sdo, 0);
      check_val("abort_done", done, 0);
      check_val("abort_valid", id_valid, 0);
      check_val("abort_word", id_word, last_word);
      repeat (3) begin
        @(negedge clk);
        #1 check_val("abort_quiet", {busy, done, sdo}, 0);
      end
    end else begin
      check_val("rst_out", {busy, sdo, sdo_strobe, done, id_valid}, 0);
      check_val("rst_word", id_word, 0);
      last_word = '0;
    end
  endtask

  initial begin
    rst = 1'b1; mask_rev = '0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_out", {busy, sdo, sdo_strobe, done, id_valid}, 0);
    check_val("reset_word", id_word, 0);

    readout(32'hA5A5_0F0F, 0, 0, 0);
    readout(32'h0000_0000, 20, 0, 0);
    readout(32'hFFFF_FFFF, 20, 0, 0);
    for (int k = 0; k < 4; k++) readout($urandom, 25, 0, 0);
    readout($urandom, 0, 1, 22);
    readout(32'h0000_0001, 0, 0, 0);
    readout($urandom, 0, 2, 81);
    readout(32'h0000_0007, 10, 0, 0);
    readout($urandom, 30, 1, 40);
    readout($urandom, 15, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
